// File: rtl/trig_unit_pkg.sv
// Shared logic-probe definitions: trigger FSM encodings, default buffer width,
// post-trigger sample count and the trigger configuration bundle.
`timescale 1ns/1ps
package trig_unit_pkg;

    localparam int AW_DEF    = 10;
    localparam int POST_SAMP = 256;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PREFILL   = 2'd1,
        ST_ARMED     = 2'd2,
        ST_TRIGGERED = 2'd3
    } trig_state_e;

    typedef struct packed {
        logic [7:0] lvl_mask;
        logic [7:0] lvl_val;
        logic [7:0] edge_mask;
        logic [7:0] edge_rise;
    } trig_cfg_t;

endpackage

// File: rtl/trig_unit_match.sv
// Combinational trigger condition: level compare on masked bits plus an
// optional edge qualifier against the previous sample.
`timescale 1ns/1ps
import trig_unit_pkg::*;

module trig_match (
    input  logic [7:0] din_i,
    input  logic [7:0] prev_i,
    input  logic       prev_valid_i,
    input  trig_cfg_t  cfg_i,
    output logic       hit_o
);

    logic       lvl_hit;
    logic       edge_hit;
    logic [7:0] rise_bits;
    logic [7:0] fall_bits;

    always_comb begin
        lvl_hit   = ((din_i ^ cfg_i.lvl_val) & cfg_i.lvl_mask) == 8'h00;
        rise_bits = ~prev_i & din_i & cfg_i.edge_mask & cfg_i.edge_rise;
        fall_bits = prev_i & ~din_i & cfg_i.edge_mask & ~cfg_i.edge_rise;
        // With no edge bits selected the edge qualifier is transparent.
        if (cfg_i.edge_mask == 8'h00) begin
            edge_hit = 1'b1;
        end else begin
            edge_hit = prev_valid_i && ((rise_bits | fall_bits) != 8'h00);
        end
        hit_o = lvl_hit && edge_hit;
    end

endmodule

// File: rtl/trig_unit.sv
// Logic-probe trigger controller: pre-trigger fill count, armed match/force,
// and capture of the write pointer on the trigger cycle.
`timescale 1ns/1ps
import trig_unit_pkg::*;

// state      | meaning
// IDLE       | waiting for arm
// PREFILL    | counting pre-trigger samples up to cfg_pre
// ARMED      | looking for match or force
// TRIGGERED  | trig held, wptr_at_trig frozen until re-arm
module trig_unit #(
    parameter int AW = AW_DEF,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_en,
    input  logic [7:0]    din_sync,
    input  logic [AW-1:0] wptr,
    input  logic          arm,
    input  logic          force_i,
    input  logic [7:0]    cfg_lvl_mask,
    input  logic [7:0]    cfg_lvl_val,
    input  logic [7:0]    cfg_edge_mask,
    input  logic [7:0]    cfg_edge_rise,
    input  logic [CW-1:0] cfg_pre,
    output logic          trig,
    output logic [AW-1:0] wptr_at_trig,
    output logic [1:0]    state_o
);

    trig_state_e   state_q, state_d;
    logic [CW-1:0] pre_cnt_q, pre_cnt_d, pre_inc;
    logic [7:0]    prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;
    logic          trig_q, trig_d;
    logic [AW-1:0] wat_q, wat_d;
    logic          hit;
    logic          fire;
    trig_cfg_t     cfg;

    assign cfg = '{lvl_mask: cfg_lvl_mask, lvl_val: cfg_lvl_val,
                   edge_mask: cfg_edge_mask, edge_rise: cfg_edge_rise};

    trig_match u_match (
        .din_i        (din_sync),
        .prev_i       (prev_q),
        .prev_valid_i (prev_valid_q),
        .cfg_i        (cfg),
        .hit_o        (hit)
    );

    assign pre_inc = (pre_cnt_q == '1) ? pre_cnt_q : pre_cnt_q + CW'(1);
    assign fire    = (state_q == ST_ARMED) && (force_i || (sample_en && hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_PREFILL;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_IDLE;
                ST_PREFILL: begin
                    if (cfg_pre == '0 || (sample_en && pre_inc == cfg_pre)) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (fire) state_d = ST_TRIGGERED;
                end
                ST_TRIGGERED: state_d = ST_TRIGGERED;
            endcase
        end
    end

    // Datapath registers follow the same arm-wins priority as the state.
    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        trig_d       = trig_q;
        wat_d        = wat_q;
        if (arm) begin
            pre_cnt_d    = '0;
            prev_valid_d = 1'b0;
            trig_d       = 1'b0;
        end else begin
            if (state_q == ST_PREFILL && sample_en) pre_cnt_d = pre_inc;
            if ((state_q == ST_PREFILL || state_q == ST_ARMED) && sample_en) begin
                prev_d       = din_sync;
                prev_valid_d = 1'b1;
            end
            if (fire) begin
                trig_d = 1'b1;
                wat_d  = wptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q    <= '0;
            prev_q       <= 8'h00;
            prev_valid_q <= 1'b0;
            trig_q       <= 1'b0;
            wat_q        <= '0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            trig_q       <= trig_d;
            wat_q        <= wat_d;
        end
    end

    always_comb begin
        trig         = trig_q;
        wptr_at_trig = wat_q;
        state_o      = state_q;
    end

endmodule

// File: tb/tb_trig_unit.sv
// Randomized and directed bench for trig_unit against a rule-level model.
`timescale 1ns/100ps

module tb_trig_unit;

    localparam int AW = 10;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_en, arm, force_i;
    logic [7:0]    din_sync;
    logic [AW-1:0] wptr;
    logic [7:0]    cfg_lvl_mask, cfg_lvl_val, cfg_edge_mask, cfg_edge_rise;
    logic [CW-1:0] cfg_pre;
    logic          trig;
    logic [AW-1:0] wptr_at_trig;
    logic [1:0]    state_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: phase 0 idle, 1 filling, 2 armed, 3 triggered.
    int            m_phase;
    int            m_cnt;
    logic [7:0]    m_prev;
    bit            m_pv;
    bit            m_trig;
    logic [AW-1:0] m_wat;

    trig_unit #(.AW(AW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .din_sync     (din_sync),
        .wptr         (wptr),
        .arm          (arm),
        .force_i      (force_i),
        .cfg_lvl_mask (cfg_lvl_mask),
        .cfg_lvl_val  (cfg_lvl_val),
        .cfg_edge_mask(cfg_edge_mask),
        .cfg_edge_rise(cfg_edge_rise),
        .cfg_pre      (cfg_pre),
        .trig         (trig),
        .wptr_at_trig (wptr_at_trig),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_prev = 8'h00; m_pv = 0; m_trig = 0; m_wat = '0;
    endtask

    function automatic bit sample_hits(input logic [7:0] d);
        bit lvl = 1;
        bit edg = (cfg_edge_mask == 8'h00);
        for (int i = 0; i < 8; i++) begin
            if (cfg_lvl_mask[i] && d[i] != cfg_lvl_val[i]) lvl = 0;
            if (cfg_edge_mask[i] && m_pv) begin
                if (cfg_edge_rise[i] && !m_prev[i] && d[i]) edg = 1;
                if (!cfg_edge_rise[i] && m_prev[i] && !d[i]) edg = 1;
            end
        end
        return lvl && edg;
    endfunction

    task automatic model_step(input bit a, input bit f, input bit se,
                              input logic [7:0] d, input logic [AW-1:0] w);
        bit fire;
        if (a) begin
            m_phase = 1; m_cnt = 0; m_pv = 0; m_trig = 0;
        end else if (m_phase == 1) begin
            if (se) begin
                m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                m_prev = d; m_pv = 1;
            end
            if (cfg_pre == 0 || (se && m_cnt == int'(cfg_pre))) m_phase = 2;
        end else if (m_phase == 2) begin
            fire = f || (se && sample_hits(d));
            if (se) begin
                m_prev = d; m_pv = 1;
            end
            if (fire) begin
                m_phase = 3; m_trig = 1; m_wat = w;
            end
        end
    endtask

    // One clock: drive inputs, model the edge, compare 1 ns later.
    task automatic cyc(input bit a, input bit f, input bit se,
                       input logic [7:0] d, input logic [AW-1:0] w);
        arm = a; force_i = f; sample_en = se; din_sync = d; wptr = w;
        @(posedge clk);
        model_step(a, f, se, d, w);
        #1;
        check("state", 32'(state_o), 32'(m_phase));
        check("trig", 32'(trig), 32'(m_trig));
        check("wptr_at_trig", 32'(wptr_at_trig), 32'(m_wat));
    endtask

    task automatic set_cfg(input logic [7:0] lm, input logic [7:0] lv,
                           input logic [7:0] em, input logic [7:0] er, input int pre);
        cfg_lvl_mask = lm; cfg_lvl_val = lv; cfg_edge_mask = em; cfg_edge_rise = er;
        cfg_pre = CW'(pre);
    endtask

    logic [AW-1:0] wp;

    initial begin
        rst_n = 1'b1; arm = 0; force_i = 0; sample_en = 0; din_sync = 0; wptr = 0;
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 0);
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_wat", 32'(wptr_at_trig), 32'd0);
        #8 rst_n = 1'b1;

        // force in IDLE is ignored
        cyc(0, 1, 1, 8'h00, 10'h001);
        check("idle_force_state", 32'(state_o), 32'd0);

        // pre-count of 4 with a constant level match
        set_cfg(8'hFF, 8'hA5, 8'h00, 8'h00, 4);
        cyc(1, 0, 0, 8'hA5, 10'h010);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 8'hA5, 10'h011);
            cyc(0, 0, 0, 8'hA5, 10'h012);
        end
        check("pre4_armed", 32'(state_o), 32'd2);
        check("pre4_no_early_trig", 32'(trig), 32'd0);
        cyc(0, 0, 1, 8'hA5, 10'h123);
        check("pre4_trig", 32'(trig), 32'd1);
        check("pre4_wat", 32'(wptr_at_trig), 32'h123);

        // re-arm: trig drops, captured pointer is kept
        cyc(1, 0, 0, 8'h00, 10'h200);
        check("rearm_trig", 32'(trig), 32'd0);
        check("rearm_wat_kept", 32'(wptr_at_trig), 32'h123);

        // rising edge on bit0 only, first sample after arm cannot trigger
        set_cfg(8'h00, 8'h00, 8'h01, 8'h01, 0);
        cyc(1, 0, 0, 8'h00, 10'h000);
        cyc(0, 0, 0, 8'h00, 10'h000);
        check("pre0_armed", 32'(state_o), 32'd2);
        cyc(0, 0, 1, 8'h01, 10'h3FD);
        check("first_sample_edge", 32'(trig), 32'd0);
        cyc(0, 0, 1, 8'h00, 10'h3FE);
        check("falling_ignored", 32'(trig), 32'd0);
        cyc(0, 0, 1, 8'h01, 10'h3FF);
        check("rise_trig", 32'(trig), 32'd1);
        check("rise_wat", 32'(wptr_at_trig), 32'h3FF);
        cyc(0, 1, 1, 8'h00, 10'h005);
        check("triggered_frozen", 32'(wptr_at_trig), 32'h3FF);

        // same edge presented as the second sample
        cyc(1, 0, 0, 8'h01, 10'h000);
        cyc(0, 0, 0, 8'h01, 10'h000);
        cyc(0, 0, 1, 8'h00, 10'h031);
        cyc(0, 0, 1, 8'h01, 10'h032);
        check("second_sample_edge", 32'(trig), 32'd1);

        // force in ARMED without a sample, then arm+force together
        set_cfg(8'hFF, 8'h00, 8'h00, 8'h00, 0);
        cyc(1, 0, 0, 8'h55, 10'h000);
        cyc(0, 0, 0, 8'h55, 10'h000);
        cyc(0, 1, 0, 8'h55, 10'h2AA);
        check("force_trig", 32'(trig), 32'd1);
        check("force_wat", 32'(wptr_at_trig), 32'h2AA);
        cyc(1, 1, 0, 8'h55, 10'h2AB);
        check("arm_force_state", 32'(state_o), 32'd1);
        check("arm_force_trig", 32'(trig), 32'd0);

        // asynchronous reset pulse while ARMED
        cyc(0, 0, 0, 8'h55, 10'h000);
        #2 rst_n = 1'b0;
        #0.5;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_trig", 32'(trig), 32'd0);
        #0.5 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 8'h00, 10'h111);
        check("post_rst_idle", 32'(state_o), 32'd0);

        // randomized traffic
        wp = 10'h3F0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                set_cfg(8'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                        8'($urandom), $urandom_range(0, CNT_MAX));
                cfg_lvl_mask = cfg_lvl_mask & 8'($urandom);
            end
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 1) == 1, 8'($urandom) & 8'h0F, wp);
            wp = wp + 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
